// File: rtl/store_monitor.sv
// Store snooper for the single-cycle core: logs every data-memory store in a FIFO
// and holds the program's pass/fail verdict. Optional watchdog: STORE_MON_TIMEOUT_EN.
module store_monitor #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] PASS_ADR    = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] SCRATCH_ADR = 32'd96
`ifdef STORE_MON_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_write,
  input  logic [31:0]              data_adr,
  input  logic [31:0]              write_data,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [31:0]              rec_adr,
  output logic [31:0]              rec_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  logic [31:0]   r_mem_adr  [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  state_t        r_state;
  state_t        w_state_nxt;

  logic w_full;
  logic w_pop;
  logic w_do_push;

  assign w_full    = (r_count == CW'(DEPTH));
  assign rec_valid = (r_count != '0);
  assign w_pop     = rec_valid && rec_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_push = mem_write && (!w_full || w_pop);

  // Head slot is masked while empty so stale entries never leak after reset.
  assign rec_adr    = rec_valid ? r_mem_adr[r_rd_ptr]  : 32'd0;
  assign rec_data   = rec_valid ? r_mem_data[r_rd_ptr] : 32'd0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem_adr[r_wr_ptr]  <= data_adr;
      r_mem_data[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (mem_write && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifdef STORE_MON_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        w_tmo_hit;

  assign w_tmo_hit = ((r_tmo_cnt + 32'd1) == 32'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // Verdict is decided by the sampled store whether or not the FIFO kept it.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN) begin
      if (mem_write) begin
        if (data_adr == PASS_ADR)
          w_state_nxt = (write_data == PASS_DATA) ? ST_PASS : ST_FAIL;
        else if (data_adr != SCRATCH_ADR)
          w_state_nxt = ST_FAIL;
      end
`ifdef STORE_MON_TIMEOUT_EN
      if ((w_state_nxt == ST_RUN) && w_tmo_hit) w_state_nxt = ST_TIMEOUT;
`endif
    end
  end

  assign done = (r_state != ST_RUN);
  assign pass = (r_state == ST_PASS);
`ifdef STORE_MON_TIMEOUT_EN
  assign timeout = (r_state == ST_TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: directed scenarios plus randomized traffic against a
// queue-based reference model. Honors STORE_MON_TIMEOUT_EN with TIMEOUT_CYC=20.
module tb_store_monitor;

  localparam int unsigned DEPTH = 8;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] write_data = '0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [31:0] rec_adr;
  logic [31:0] rec_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {adr,data}, sticky overflow, verdict 0=RUN 1=PASS 2=FAIL 3=TIMEOUT.
  logic [63:0] m_q[$];
  logic        m_ovf;
  int          m_state;
  int          m_run_cyc;

  store_monitor #(
    .DEPTH(DEPTH),
    .PASS_ADR(32'd100),
    .PASS_DATA(32'd7),
    .SCRATCH_ADR(32'd96)
`ifdef STORE_MON_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_write(mem_write),
    .data_adr(data_adr),
    .write_data(write_data),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_adr(rec_adr),
    .rec_data(rec_data),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .done(done),
    .pass(pass),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_q.delete();
    m_ovf = 1'b0;
    m_state = 0;
    m_run_cyc = 0;
  endtask

  // Drive one cycle from the negedge, advance the model at the posedge, return at next negedge.
  task automatic cycle(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit popping;
    mem_write = mw; data_adr = a; write_data = d; rec_ready = rdy;
    @(posedge clk);
    popping = (m_q.size() > 0) && rdy;
    if (popping) void'(m_q.pop_front());
    if (mw) begin
      if (m_q.size() < DEPTH) m_q.push_back({a, d});
      else m_ovf = 1'b1;
    end
    if (m_state == 0) begin
      if (mw && a == 32'd100) m_state = (d == 32'd7) ? 1 : 2;
      else if (mw && a != 32'd96) m_state = 2;
`ifdef STORE_MON_TIMEOUT_EN
      m_run_cyc++;
      if (m_state == 0 && m_run_cyc == TMO) m_state = 3;
`endif
    end
    @(negedge clk);
    mem_write = 1'b0; rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_write = 1'b0; rec_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  function automatic logic [72:0] expected_vec();
    logic [31:0] ha, hd;
    ha = (m_q.size() > 0) ? m_q[0][63:32] : 32'd0;
    hd = (m_q.size() > 0) ? m_q[0][31:0]  : 32'd0;
    return {m_q.size() > 0, 4'(m_q.size()), m_ovf, m_state != 0, m_state == 1, m_state == 3, ha, hd};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rec_valid, fifo_count, overflow, done, pass, timeout, rec_adr, rec_data} !== 73'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0",
               {rec_valid, fifo_count, overflow, done, pass, timeout, rec_adr, rec_data});
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_pass();
    do_reset();
    cycle(1'b1, 32'd96, 32'd5, 1'b0);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL scratch_no_verdict: done=%b want 0", done); end
    cycle(1'b1, 32'd100, 32'd7, 1'b0);
    n_cmp++;
    if ({fifo_count, done, pass} !== {4'd2, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL pass_verdict: count=%0d done=%b pass=%b want 2 1 1", fifo_count, done, pass);
    end
    n_cmp++;
    if ({rec_adr, rec_data} !== {32'd96, 32'd5}) begin
      n_err++; $display("FAIL pass_head: got (%0d,%0d) want (96,5)", rec_adr, rec_data);
    end
  endtask

  task automatic test_fail();
    do_reset();
    cycle(1'b1, 32'd100, 32'd3, 1'b0);
    n_cmp++;
    if ({done, pass} !== 2'b10) begin n_err++; $display("FAIL fail_verdict: done=%b pass=%b want 1 0", done, pass); end
    cycle(1'b1, 32'd100, 32'd7, 1'b0);
    n_cmp++;
    if ({done, pass} !== 2'b10) begin n_err++; $display("FAIL fail_sticky: done=%b pass=%b want 1 0", done, pass); end
  endtask

  task automatic test_bad_adr();
    do_reset();
    cycle(1'b1, 32'd104, 32'd1, 1'b0);
    n_cmp++;
    if ({done, pass, rec_valid} !== 3'b101) begin
      n_err++; $display("FAIL bad_adr_verdict: done=%b pass=%b valid=%b want 1 0 1", done, pass, rec_valid);
    end
    n_cmp++;
    if ({rec_adr, rec_data} !== {32'd104, 32'd1}) begin
      n_err++; $display("FAIL bad_adr_logged: got (%0d,%0d) want (104,1)", rec_adr, rec_data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'd96, 32'(i), 1'b0);
    n_cmp++;
    if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
      n_err++; $display("FAIL fill_8: count=%0d ovf=%b want 8 0", fifo_count, overflow);
    end
    cycle(1'b1, 32'd96, 32'd8, 1'b0);
    n_cmp++;
    if ({fifo_count, overflow} !== {4'd8, 1'b1}) begin
      n_err++; $display("FAIL drop_9th: count=%0d ovf=%b want 8 1", fifo_count, overflow);
    end
    cycle(1'b1, 32'd96, 32'd99, 1'b1);
    n_cmp++;
    if ({fifo_count, overflow, rec_data} !== {4'd8, 1'b1, 32'd1}) begin
      n_err++; $display("FAIL full_push_pop: count=%0d ovf=%b head=%0d want 8 1 1", fifo_count, overflow, rec_data);
    end
    for (int i = 1; i <= 8; i++) begin
      want = (i == 8) ? 32'd99 : 32'(i);
      n_cmp++;
      if ({rec_valid, rec_data} !== {1'b1, want}) begin
        n_err++; $display("FAIL drain_order[%0d]: valid=%b data=%0d want 1 %0d", i, rec_valid, rec_data, want);
      end
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_cmp++;
    if ({rec_valid, fifo_count, rec_adr} !== {1'b0, 4'd0, 32'd0}) begin
      n_err++; $display("FAIL drained_empty: valid=%b count=%0d adr=%0d want 0 0 0", rec_valid, fifo_count, rec_adr);
    end
    cycle(1'b1, 32'd96, 32'd42, 1'b1);
    n_cmp++;
    if ({fifo_count, rec_data} !== {4'd1, 32'd42}) begin
      n_err++; $display("FAIL empty_push_pop: count=%0d data=%0d want 1 42", fifo_count, rec_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 32'd96, 32'd1, 1'b0);
    cycle(1'b1, 32'd104, 32'd2, 1'b0);
    cycle(1'b1, 32'd96, 32'd3, 1'b0);
    n_cmp++;
    if ({fifo_count, done} !== {4'd3, 1'b1}) begin
      n_err++; $display("FAIL pre_mid_reset: count=%0d done=%b want 3 1", fifo_count, done);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rec_valid, fifo_count, done, pass, rec_adr, rec_data} !== 71'd0) begin
      n_err++; $display("FAIL mid_reset: valid=%b count=%0d done=%b pass=%b adr=%0d data=%0d want all 0",
                        rec_valid, fifo_count, done, pass, rec_adr, rec_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef STORE_MON_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) cycle(1'b1, 32'd96, 32'(i), 1'b1);
    n_cmp++;
    if ({done, timeout} !== 2'b00) begin n_err++; $display("FAIL tmo_early: done=%b tmo=%b want 0 0", done, timeout); end
    cycle(1'b1, 32'd96, 32'd0, 1'b1);
    n_cmp++;
    if ({done, pass, timeout} !== 3'b101) begin
      n_err++; $display("FAIL tmo_hit: done=%b pass=%b tmo=%b want 1 0 1", done, pass, timeout);
    end
`else
    for (int i = 0; i < TMO + 5; i++) cycle(1'b1, 32'd96, 32'(i), 1'b1);
    n_cmp++;
    if ({done, timeout} !== 2'b00) begin n_err++; $display("FAIL no_tmo: done=%b tmo=%b want 0 0", done, timeout); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [72:0] exp_v, got_v;
    int sel;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 100; i++) begin
        sel = $urandom_range(0, 39);
        if (sel < 36)      a = 32'd96;
        else if (sel < 38) a = 32'd100;
        else               a = $urandom;
        cycle(1'($urandom_range(0, 1)), a, (sel == 36) ? 32'd7 : 32'($urandom_range(0, 9)),
              1'($urandom_range(0, 2) == 0));
        exp_v = expected_vec();
        got_v = {rec_valid, fifo_count, overflow, done, pass, timeout, rec_adr, rec_data};
        n_cmp++;
        if (got_v !== exp_v) begin
          n_err++; $display("FAIL random[%0d.%0d]: got %h want %h", blk, i, got_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_pass();
    test_fail();
    test_bad_adr();
    test_overflow();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
